id_stage_pipe: RTL
==================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage with integrated ID/EX pipeline register. Decodes instr_in,
//  reads a DEPTH-entry register file, and resolves beq in ID with EX-stage forwarding.
//  Detects load-use hazards and issues stall/bubble.
//  Sits between the IF/ID register and the EX stage; all EX-side outputs are registered.
// PARAMETERS
//  DATA_W   8   register/data width
//  DEPTH    8   register-file entries (power of 2)
//  ADDR_W   3   register address width, log2(DEPTH)
//  IMM_W    6   immediate field width taken from instr_in[IMM_W-1:0]
//  PC_W     6   program-counter width (word-addressed)
// PORTS
//  clk            in   1       clock, all state updates on rising edge
//  rst            in   1       synchronous reset, active-high
//  instr_in       in   32      instruction from IF/ID
//  pc_next_in     in   PC_W    PC+1 of this instruction
//  wb_we          in   1       write-back enable
//  wb_addr        in   ADDR_W  write-back register
//  wb_data        in   DATA_W  write-back data
//  ex_rd, ex_reg_write, ex_mem_read  in  ADDR_W,1,1  dest/ctrl of instr currently in EX
//  ex_alu_result  in   DATA_W  EX ALU result (branch forwarding)
//  flush_in       in   1       exception flush: squash instr in ID
//  stall          out  1       comb: hold PC and IF/ID this cycle
//  branch_taken   out  1       comb: redirect PC, flush IF/ID
//  branch_target  out  PC_W    comb: pc_next_in + sext(imm), mod 2^PC_W
//  illegal_op     out  1       comb: opcode not recognised
//  idex_rs_data, idex_rt_data  out DATA_W  registered operands
//  idex_imm       out  DATA_W  registered sign-extended immediate
//  idex_rs, idex_rt, idex_rd  out ADDR_W  registered register addresses
//  idex_ctrl      out  9       {RegWrite,MemtoReg,MemWrite,MemRead,ALUSrc,RegDst,Branch,ALUop[1:0]}
// BEHAVIOUR
//  - Fields: op=[31:26], rs=[21+:ADDR_W], rt=[16+:ADDR_W], rd=[11+:ADDR_W].
//  - Decode: 000000 R: RegWrite,RegDst,ALUop=10; 100011 lw: RegWrite,MemtoReg,MemRead,ALUSrc,ALUop=00;
//    101011 sw: MemWrite,ALUSrc,ALUop=00; 000100 beq: Branch,ALUop=01; else all 0, illegal_op=1.
//  - Regfile: reg 0 reads 0, writes to 0 ignored; write on clk when wb_we. Same-cycle read of
//    wb_addr returns wb_data (write-through bypass). rst clears all entries to 0.
//  - Branch operands: if ex_reg_write && !ex_mem_read && ex_rd!=0 && ex_rd==rs(rt) use ex_alu_result,
//    else bypassed regfile value. equal = (opA==opB), full DATA_W compare.
//  - stall=1 if ex_mem_read && ex_rd!=0 && (ex_rd==rs || (ex_rd==rt && op uses rt: R,sw,beq)).
//    stall=1 also if Branch && ex_reg_write && ex_rd!=0 && ex_rd matches rs/rt and ex_mem_read.
//  - branch_taken = Branch && equal && !stall && !flush_in.
//  - ID/EX register priority: rst > flush_in > stall > load. rst/flush_in/stall load a bubble:
//    idex_ctrl=0, all data/address outputs 0. Otherwise load decoded values. Latency 1 cycle.
//  - Reset values: all registered outputs 0; comb outputs follow inputs (regfile zero).
//  - Reset mid-operation discards the in-flight ID/EX contents; no state survives rst.
// CONFIGURATION
//  BNE_EN defined: opcode 000101 (bne) decodes as beq with inverted compare: Branch=1, ALUop=01,
//   branch_taken = Branch && !equal && !stall && !flush_in; idex_ctrl carries Branch only.
//  BNE_EN undefined: 000101 is illegal (illegal_op=1, bubble-equivalent controls).
// TESTING
//  1 rst=1 one cycle -> all idex_* = 0, stall=0; read any reg -> 0.
//  2 wb_we=1,wb_addr=3,wb_data=8'hA5 while instr reads rs=3 -> idex_rs_data=8'hA5 next cycle.
//  3 EX lw ex_rd=2, ID R-type rt=2 -> stall=1, idex_ctrl=0 next cycle; then stall=0, reload.
//  4 EX add ex_rd=1 ex_alu_result=5, ID beq rs=1 rt=4 (r4=5) -> branch_taken=1,
//    branch_target=pc_next_in+imm (pc_next=6'd10,imm=6'h3E -> 6'd8).
//  5 flush_in=1 with valid lw in ID -> idex_ctrl=0, branch_taken=0.
//  6 BNE_EN: bne r1=7,r2=7 -> taken=0; r2=6 -> taken=1; without macro illegal_op=1.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with integrated ID/EX pipeline register.
// Decodes instr_in, reads a write-through register file, resolves beq in ID with
// EX-stage forwarding, and raises stall on load-use hazards.
// Optional feature macro: BNE_EN (adds bne, opcode 000101, as an inverted-compare beq).
module id_stage_pipe #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int IMM_W  = 6,
    parameter int PC_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_in,
    input  logic [PC_W-1:0]   pc_next_in,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              flush_in,
    output logic              stall,
    output logic              branch_taken,
    output logic [PC_W-1:0]   branch_target,
    output logic              illegal_op,
    output logic [DATA_W-1:0] idex_rs_data,
    output logic [DATA_W-1:0] idex_rt_data,
    output logic [DATA_W-1:0] idex_imm,
    output logic [ADDR_W-1:0] idex_rs,
    output logic [ADDR_W-1:0] idex_rt,
    output logic [ADDR_W-1:0] idex_rd,
    output logic [8:0]        idex_ctrl
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101
    } opcode_e;

    // {RegWrite,MemtoReg,MemWrite,MemRead,ALUSrc,RegDst,Branch,ALUop[1:0]}
    localparam logic [8:0] CTRL_R  = 9'b100001010;
    localparam logic [8:0] CTRL_LW = 9'b110110000;
    localparam logic [8:0] CTRL_SW = 9'b001010000;
    localparam logic [8:0] CTRL_BR = 9'b000000101;

    opcode_e           op;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic [31:0]       imm_wide;
    logic [8:0]        ctrl_dec;
    logic              uses_rt, is_bne;
    logic [DATA_W-1:0] rs_val, rt_val, br_a, br_b;
    logic              branch_eq, load_use, branch_hz;
    logic              unused_ok;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];

    logic [DATA_W-1:0] idex_rs_data_q, idex_rs_data_d;
    logic [DATA_W-1:0] idex_rt_data_q, idex_rt_data_d;
    logic [DATA_W-1:0] idex_imm_q, idex_imm_d;
    logic [ADDR_W-1:0] idex_rs_q, idex_rs_d;
    logic [ADDR_W-1:0] idex_rt_q, idex_rt_d;
    logic [ADDR_W-1:0] idex_rd_q, idex_rd_d;
    logic [8:0]        idex_ctrl_q, idex_ctrl_d;

    assign op       = opcode_e'(instr_in[31:26]);
    assign rs       = instr_in[21 +: ADDR_W];
    assign rt       = instr_in[16 +: ADDR_W];
    assign rd       = instr_in[11 +: ADDR_W];
    assign imm_wide = {{(32-IMM_W){instr_in[IMM_W-1]}}, instr_in[IMM_W-1:0]};
    assign unused_ok = ^{instr_in, imm_wide};

    // Opcode decode into control word, illegal flag and rt-usage for hazard checks
    always_comb begin
        ctrl_dec   = '0;
        illegal_op = 1'b0;
        uses_rt    = 1'b0;
        is_bne     = 1'b0;
        case (op)
            OP_RTYPE: begin ctrl_dec = CTRL_R;  uses_rt = 1'b1; end
            OP_LW:    begin ctrl_dec = CTRL_LW; end
            OP_SW:    begin ctrl_dec = CTRL_SW; uses_rt = 1'b1; end
            OP_BEQ:   begin ctrl_dec = CTRL_BR; uses_rt = 1'b1; end
`ifdef BNE_EN
            OP_BNE:   begin ctrl_dec = CTRL_BR; uses_rt = 1'b1; is_bne = 1'b1; end
`endif
            default:  illegal_op = 1'b1;
        endcase
    end

    // Register-file reads with same-cycle write-back bypass; r0 is hardwired zero
    always_comb begin
        rs_val = rf_q[rs];
        rt_val = rf_q[rt];
        if (wb_we && wb_addr == rs) rs_val = wb_data;
        if (wb_we && wb_addr == rt) rt_val = wb_data;
        if (rs == '0) rs_val = '0;
        if (rt == '0) rt_val = '0;
    end

    // Branch operands: forward EX ALU result unless EX is a load (handled by stall)
    always_comb begin
        br_a = rs_val;
        br_b = rt_val;
        if (ex_reg_write && !ex_mem_read && ex_rd != '0 && ex_rd == rs) br_a = ex_alu_result;
        if (ex_reg_write && !ex_mem_read && ex_rd != '0 && ex_rd == rt) br_b = ex_alu_result;
        branch_eq = (br_a == br_b);
    end

    // Hazard detection, branch resolution and target computation
    always_comb begin
        load_use  = ex_mem_read && ex_rd != '0 && (ex_rd == rs || (ex_rd == rt && uses_rt));
        branch_hz = ctrl_dec[2] && ex_reg_write && ex_mem_read && ex_rd != '0
                    && (ex_rd == rs || ex_rd == rt);
        stall         = load_use || branch_hz;
        branch_taken  = ctrl_dec[2] && (is_bne ? !branch_eq : branch_eq) && !stall && !flush_in;
        branch_target = pc_next_in + imm_wide[PC_W-1:0];
    end

    // Next register-file contents; writes to r0 are dropped
    always_comb begin
        rf_d = rf_q;
        if (wb_we && wb_addr != '0) rf_d[wb_addr] = wb_data;
    end

    // Next ID/EX contents: flush and stall both insert a bubble
    always_comb begin
        idex_ctrl_d    = '0;
        idex_rs_data_d = '0;
        idex_rt_data_d = '0;
        idex_imm_d     = '0;
        idex_rs_d      = '0;
        idex_rt_d      = '0;
        idex_rd_d      = '0;
        if (!flush_in && !stall) begin
            idex_ctrl_d    = ctrl_dec;
            idex_rs_data_d = rs_val;
            idex_rt_data_d = rt_val;
            idex_imm_d     = imm_wide[DATA_W-1:0];
            idex_rs_d      = rs;
            idex_rt_d      = rt;
            idex_rd_d      = rd;
        end
    end

    // State update: reset clears the register file and the ID/EX register
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q           <= '{default: '0};
            idex_ctrl_q    <= '0;
            idex_rs_data_q <= '0;
            idex_rt_data_q <= '0;
            idex_imm_q     <= '0;
            idex_rs_q      <= '0;
            idex_rt_q      <= '0;
            idex_rd_q      <= '0;
        end else begin
            rf_q           <= rf_d;
            idex_ctrl_q    <= idex_ctrl_d;
            idex_rs_data_q <= idex_rs_data_d;
            idex_rt_data_q <= idex_rt_data_d;
            idex_imm_q     <= idex_imm_d;
            idex_rs_q      <= idex_rs_d;
            idex_rt_q      <= idex_rt_d;
            idex_rd_q      <= idex_rd_d;
        end
    end

    assign idex_ctrl    = idex_ctrl_q;
    assign idex_rs_data = idex_rs_data_q;
    assign idex_rt_data = idex_rt_data_q;
    assign idex_imm     = idex_imm_q;
    assign idex_rs      = idex_rs_q;
    assign idex_rt      = idex_rt_q;
    assign idex_rd      = idex_rd_q;

endmodule
